// File: rtl/clock_pkg.sv
// Constants shared by the stopwatch counter chain: FSM state encoding,
// BCD digit limits and a small digit-range helper.
package clock_pkg;

    // Stopwatch control states, 2-bit encoding shared with the minute counter
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    // BCD limits for the seconds and minutes digits
    localparam logic [3:0] UNITS_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;

    // True when a digit lies inside 0..max
    function automatic logic digit_ok(input logic [3:0] digit, input logic [3:0] max);
        return digit <= max;
    endfunction

endpackage : clock_pkg

// File: rtl/key_debounce.sv
// Raw key conditioning: two-flop synchronizer followed by a debounce counter.
// 'level' is the accepted key level (1 = released); 'press' is a one-cycle
// pulse on each accepted 1->0 transition. Releases produce no pulse.
module key_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; the next differing sample commits.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Bring the asynchronous key into the clk domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts the count.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule : key_debounce

// File: rtl/second_counter_ctrl.sv
// Seconds stage of the stopwatch: key conditioning, IDLE/RUN/PAUSE control,
// 1 Hz prescaler and the two-digit BCD seconds counter with rollover carry.
module second_counter_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_start_n,
    input  logic       key_clr_n,
    output logic [3:0] SL,
    output logic [3:0] SH,
    output logic       co,
    output logic       run_n
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    localparam int KEY_START = 0;
    localparam int KEY_CLR   = 1;
    localparam int NUM_KEYS  = 2;

    logic [NUM_KEYS-1:0] key_raw_n;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic                unused_key_level;

    logic start_ev;
    logic clr_ev;
    logic tick;

    state_e           state_q;
    logic             run_n_q;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic [3:0]       sl_q;
    logic [3:0]       sl_d;
    logic [3:0]       sh_q;
    logic [3:0]       sh_d;
    logic             co_q;
    logic             co_d;

    assign key_raw_n = {key_clr_n, key_start_n};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .clk   (clk),
                .reset (reset),
                .key_n (key_raw_n[gi]),
                .level (key_level[gi]),
                .press (key_press[gi])
            );
        end
    endgenerate

    // Accepted levels are not needed here; only the press edges drive control.
    assign unused_key_level = ^key_level;

    assign start_ev = key_press[KEY_START];
    assign clr_ev   = key_press[KEY_CLR];

    // One tick per DIV cycles of RUN, aligned with the prescaler wrap
    assign tick = (state_q == RUN) && (pre_q == PRE_LAST);

    // Control FSM: clear beats start; run_n is registered alongside the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            run_n_q <= 1'b1;
        end else if (clr_ev) begin
            state_q <= IDLE;
            run_n_q <= 1'b1;
        end else if (start_ev) begin
            case (state_q)
                IDLE: begin
                    state_q <= RUN;
                    run_n_q <= 1'b0;
                end
                RUN: begin
                    state_q <= PAUSE;
                    run_n_q <= 1'b1;
                end
                PAUSE: begin
                    state_q <= RUN;
                    run_n_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    run_n_q <= 1'b1;
                end
            endcase
        end else if ((state_q != IDLE) && (state_q != RUN) && (state_q != PAUSE)) begin
            // Recover from the unused encoding
            state_q <= IDLE;
            run_n_q <= 1'b1;
        end
    end

    // Prescaler next value: counts in RUN, holds in PAUSE so resume keeps the partial second
    always_comb begin
        pre_d = pre_q;
        if (clr_ev || (state_q != RUN && state_q != PAUSE)) begin
            pre_d = '0;
        end else if (state_q == RUN) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        end
    end

    // Prescaler register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // Seconds counter next value; co is raised with the 59->00 step so it
    // coincides with the first cycle that shows 00.
    always_comb begin
        sl_d = sl_q;
        sh_d = sh_q;
        co_d = 1'b0;
        if (clr_ev || (state_q == IDLE)) begin
            sl_d = 4'd0;
            sh_d = 4'd0;
        end else if (tick) begin
            if (!digit_ok(sl_q, UNITS_MAX) || !digit_ok(sh_q, SEC_TENS_MAX)) begin
                sl_d = 4'd0;
                sh_d = 4'd0;
            end else if (sl_q < UNITS_MAX) begin
                sl_d = sl_q + 4'd1;
            end else if (sh_q < SEC_TENS_MAX) begin
                sl_d = 4'd0;
                sh_d = sh_q + 4'd1;
            end else begin
                sl_d = 4'd0;
                sh_d = 4'd0;
                co_d = 1'b1;
            end
        end
    end

    // Seconds digits and carry registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sl_q <= 4'd0;
            sh_q <= 4'd0;
            co_q <= 1'b0;
        end else begin
            sl_q <= sl_d;
            sh_q <= sh_d;
            co_q <= co_d;
        end
    end

    assign SL    = sl_q;
    assign SH    = sh_q;
    assign co    = co_q;
    assign run_n = run_n_q;

endmodule : second_counter_ctrl

// File: tb/tb_second_counter_ctrl.sv
// Directed bench for second_counter_ctrl with DIV=10 and DEBOUNCE_CYCLES=4.
// Keys are driven 1 time unit after a rising edge; a key applied after edge
// t0 produces its FSM transition at edge t0+7 (2 sync + 4 debounce + 1 FSM).
module tb_second_counter_ctrl;

    logic       clk;
    logic       reset;
    logic       key_start_n;
    logic       key_clr_n;
    logic [3:0] SL;
    logic [3:0] SH;
    logic       co;
    logic       run_n;

    int n_checks = 0;
    int n_fail   = 0;

    second_counter_ctrl #(
        .CLK_HZ          (10),
        .TICK_HZ         (1),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_start_n (key_start_n),
        .key_clr_n   (key_clr_n),
        .SL          (SL),
        .SH          (SH),
        .co          (co),
        .run_n       (run_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {SH,SL} for an elapsed-seconds count
    function automatic logic [7:0] bcd_of(input int secs);
        int s;
        s = secs % 60;
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic set_keys(input logic ks, input logic kc, input int i);
        key_start_n = ks;
        key_clr_n   = kc;
        $display("keys start_n=%0b clr_n=%0b after step %0d", ks, kc, i);
    endtask

    int   cnt_exp;
    logic rn_exp;
    int   co_seen;

    initial begin
        reset       = 1'b0;
        key_start_n = 1'b1;
        key_clr_n   = 1'b1;
        co_seen     = 0;

        // Reset held: every output at its reset value
        repeat (3) step();
        check("reset_state", {SH, SL, co, run_n}, {4'd0, 4'd0, 1'b0, 1'b1});
        reset = 1'b1;

        // Test 1: idle for 50 clk, nothing moves
        for (int i = 0; i < 50; i++) begin
            step();
            check("idle", {SH, SL, co, run_n}, {4'd0, 4'd0, 1'b0, 1'b1});
        end
        $display("idle phase done");

        // Tests 2..6 as one timeline; i counts edges after the first start press
        set_keys(1'b0, 1'b1, 0);
        for (int i = 1; i <= 1182; i++) begin
            step();
            if (i < 7) begin
                cnt_exp = 0;              rn_exp = 1'b1;   // debouncing start
            end else if (i < 643) begin
                cnt_exp = (i - 7) / 10;   rn_exp = 1'b0;   // RUN from 00
            end else if (i < 690) begin
                cnt_exp = 63;             rn_exp = 1'b1;   // PAUSE at 03, prescaler 6
            end else if (i < 1127) begin
                cnt_exp = 63 + (i - 684) / 10; rn_exp = 1'b0; // resumed, 4 clk to next second
            end else if (i < 1157) begin
                cnt_exp = 0;              rn_exp = 1'b1;   // cleared to IDLE
            end else begin
                cnt_exp = (i - 1157) / 10; rn_exp = 1'b0;  // restarted from 00
            end
            check("run_n", {31'd0, run_n}, {31'd0, rn_exp});
            check("secs", {24'd0, SH, SL}, {24'd0, bcd_of(cnt_exp)});
            check("co", {31'd0, co}, {31'd0, (i == 607)});
            if (co) co_seen++;
            if (i == 1126) check("at_4_7_before_clear", {24'd0, SH, SL}, 32'h47);

            if (i >= 710 && i < 730) begin
                // Bounce: start key toggles every 2 clk, never stable for 4 samples
                set_keys((((i - 710) / 2) % 2) == 1, 1'b1, i);
            end else begin
                case (i)
                    10:   set_keys(1'b1, 1'b1, i);
                    636:  set_keys(1'b0, 1'b1, i);  // pause lands at SL=3, prescaler=6
                    646:  set_keys(1'b1, 1'b1, i);
                    683:  set_keys(1'b0, 1'b1, i);  // resume after 40 clk paused
                    693:  set_keys(1'b1, 1'b1, i);
                    730:  set_keys(1'b1, 1'b1, i);
                    1120: set_keys(1'b0, 1'b0, i);  // clear and start together at 4:7
                    1130: set_keys(1'b1, 1'b1, i);
                    1150: set_keys(1'b0, 1'b1, i);
                    1160: set_keys(1'b1, 1'b1, i);
                    default: ;
                endcase
            end
        end
        check("co_pulse_count", co_seen, 1);

        // Reset asserted between edges: outputs return immediately
        #1 reset = 1'b0;
        #1;
        $display("async reset asserted mid-count");
        check("async_reset", {SH, SL, co, run_n}, {4'd0, 4'd0, 1'b0, 1'b1});
        repeat (3) step();
        check("reset_hold", {SH, SL, co, run_n}, {4'd0, 4'd0, 1'b0, 1'b1});
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("post_reset_idle", {SH, SL, co, run_n}, {4'd0, 4'd0, 1'b0, 1'b1});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_second_counter_ctrl
